// File: rtl/rv32i_stream_loader.sv
// rv32i_stream_loader: byte-stream program loader for rv32i_soc.
// Builds LE words from a host byte stream, writes ROM/RAM, then releases core reset.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rx_data/valid/ready byte stream in (ready low only in RUN)
//   inst_wr_en/addr/wr_data          instruction memory write port
//   data_wr_en/addr/wr_data/wr_mask  data memory write port
//   core_rst_n          core reset, released by the RUN command
//   busy, err           frame in progress, sticky error
// Options:
//   LOADER_CHECKSUM_EN  each load frame ends with an 8-bit payload sum byte
module rv32i_stream_loader #(
  parameter int ROM_DEPTH = 8192,
  parameter int RAM_DEPTH = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        inst_wr_en,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wr_data,
  output logic        data_wr_en,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_wr_mask,
  output logic        core_rst_n,
  output logic        busy,
  output logic        err
);

  localparam logic [32:0] ROM_LIM = 33'(ROM_DEPTH);
  localparam logic [32:0] RAM_LIM = 33'(RAM_DEPTH);

  localparam logic [7:0] CMD_TEXT = 8'hA1;
  localparam logic [7:0] CMD_DATA = 8'hA2;
  localparam logic [7:0] CMD_RUN  = 8'hA3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ADDR,
    S_LEN,
    S_PAY
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      r_state;
  logic        r_rx_ready;
  logic        r_core_rst_n;
  logic        r_err;
  logic        r_inst_we;
  logic [31:0] r_inst_addr;
  logic [31:0] r_inst_data;
  logic        r_data_we;
  logic [31:0] r_data_addr;
  logic [31:0] r_data_data;
  logic [3:0]  r_mask;
  logic [31:0] r_base;
  logic [7:0]  r_len_lo;
  logic [15:0] r_words;
  logic [31:0] r_waddr;
  logic [23:0] r_word;
  logic [1:0]  r_cnt;
  logic        r_is_data;
  logic        r_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  logic        w_acc;
  logic        w_cmd_text;
  logic        w_cmd_data;
  logic        w_cmd_run;
  logic [15:0] w_len;
  logic [32:0] w_end;
  logic [32:0] w_lim;
  logic        w_ok;
  logic [31:0] w_word;
  state_t      w_tail;

  assign w_acc      = rx_valid && r_rx_ready;
  assign w_cmd_text = (rx_data == CMD_TEXT);
  assign w_cmd_data = (rx_data == CMD_DATA);
  assign w_cmd_run  = (rx_data == CMD_RUN);

  // Range check in 33 bits so base+4N cannot wrap past 2^32.
  assign w_len = {rx_data, r_len_lo};
  assign w_end = {1'b0, r_base} + {15'd0, w_len, 2'b00};
  assign w_lim = r_is_data ? RAM_LIM : ROM_LIM;
  assign w_ok  = (r_base[1:0] == 2'b00) && (w_end <= w_lim);

  // First received byte lands in the LSB.
  assign w_word = {rx_data, r_word};

`ifdef LOADER_CHECKSUM_EN
  assign w_tail = S_CSUM;
`else
  assign w_tail = S_IDLE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rx_ready   <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_err        <= 1'b0;
      r_inst_we    <= 1'b0;
      r_inst_addr  <= '0;
      r_inst_data  <= '0;
      r_data_we    <= 1'b0;
      r_data_addr  <= '0;
      r_data_data  <= '0;
      r_mask       <= '0;
      r_base       <= '0;
      r_len_lo     <= '0;
      r_words      <= '0;
      r_waddr      <= '0;
      r_word       <= '0;
      r_cnt        <= '0;
      r_is_data    <= 1'b0;
      r_ok         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_inst_we <= 1'b0;
      r_data_we <= 1'b0;
      if (r_state != S_RUN)
        r_rx_ready <= 1'b1;

      if (w_acc) begin
        unique case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            unique case (1'b1)
              w_cmd_text, w_cmd_data: begin
                r_is_data <= w_cmd_data;
                r_state   <= S_ADDR;
              end
              w_cmd_run: begin
                r_state      <= S_RUN;
                r_core_rst_n <= 1'b1;
                r_rx_ready   <= 1'b0;
              end
              default: r_err <= 1'b1;
            endcase
          end

          S_ADDR: begin
            r_base <= {rx_data, r_base[31:8]};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3)
              r_state <= S_LEN;
          end

          S_LEN: begin
            if (r_cnt == 2'd0) begin
              r_len_lo <= rx_data;
              r_cnt    <= 2'd1;
            end else begin
              r_cnt   <= '0;
              r_words <= w_len;
              r_waddr <= r_base;
              r_ok    <= w_ok;
              if (!w_ok)
                r_err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              r_sum <= '0;
`endif
              r_state <= (w_len == 16'd0) ? w_tail : S_PAY;
            end
          end

          S_PAY: begin
            r_word <= w_word[31:8];
            r_cnt  <= r_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum  <= r_sum + rx_data;
`endif
            if (r_cnt == 2'd3) begin
              // Rejected frames are drained without writing.
              if (r_ok) begin
                if (r_is_data) begin
                  r_data_we   <= 1'b1;
                  r_data_addr <= r_waddr;
                  r_data_data <= w_word;
                  r_mask      <= 4'hF;
                end else begin
                  r_inst_we   <= 1'b1;
                  r_inst_addr <= r_waddr;
                  r_inst_data <= w_word;
                end
              end
              r_waddr <= r_waddr + 32'd4;
              r_words <= r_words - 16'd1;
              if (r_words == 16'd1)
                r_state <= w_tail;
            end
          end

`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (rx_data != r_sum)
              r_err <= 1'b1;
            r_state <= S_IDLE;
          end
`endif

          S_RUN: begin
            r_state <= S_RUN;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_ready     = r_rx_ready;
  assign inst_wr_en   = r_inst_we;
  assign inst_addr    = r_inst_addr;
  assign inst_wr_data = r_inst_data;
  assign data_wr_en   = r_data_we;
  assign data_addr    = r_data_addr;
  assign data_wr_data = r_data_data;
  assign data_wr_mask = r_mask;
  assign core_rst_n   = r_core_rst_n;
  assign busy         = (r_state != S_IDLE) && (r_state != S_RUN);
  assign err          = r_err;

endmodule

// File: tb/tb_rv32i_stream_loader.sv
// tb_rv32i_stream_loader: directed bench with a write scoreboard.
// Frames are built by tasks; expected writes are queued and checked by a monitor.
module tb_rv32i_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        inst_wr_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_wr_data;
  logic        data_wr_en;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_wr_mask;
  logic        core_rst_n;
  logic        busy;
  logic        err;

  rv32i_stream_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .inst_wr_en   (inst_wr_en),
    .inst_addr    (inst_addr),
    .inst_wr_data (inst_wr_data),
    .data_wr_en   (data_wr_en),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_wr_mask (data_wr_mask),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  logic [31:0] pw[$];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (inst_wr_en || data_wr_en) begin
      if (q.size() == 0) begin
        check("unexp_wr", {62'd0, inst_wr_en, data_wr_en}, 64'd0);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("wr_sel", {62'd0, inst_wr_en, data_wr_en},
              e.sel ? 64'd1 : 64'd2);
        check("wr_addr", data_wr_en ? data_addr : inst_addr, e.a);
        check("wr_data", data_wr_en ? data_wr_data : inst_wr_data, e.d);
        if (data_wr_en)
          check("wr_mask", data_wr_mask, 4'hF);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready)
      check("rdy_timeout", rx_ready, 1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [31:0] base,
                       input int n, input bit ok, input int gap,
                       input bit bad_sum);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [15:0] len;
    wr_t         e;
    sum = 8'd0;
    len = 16'(n);
    send(cmd, gap);
    for (int i = 0; i < 4; i++)
      send(base[8*i +: 8], gap);
    send(len[7:0], gap);
    send(len[15:8], gap);
    for (int k = 0; k < n; k++) begin
      w = pw[k];
      if (ok) begin
        e.sel = (cmd == 8'hA2);
        e.a   = base + 32'(4 * k);
        e.d   = w;
        q.push_back(e);
      end
      for (int i = 0; i < 4; i++) begin
        sum = sum + w[8*i +: 8];
        send(w[8*i +: 8], gap);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send(bad_sum ? sum + 8'd1 : sum, gap);
`else
    if (bad_sum)
      $display("note: checksum option not built");
`endif
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_drain"}, q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_ctl"},
          {58'd0, rx_ready, inst_wr_en, data_wr_en, busy, err, core_rst_n},
          64'd0);
    check({tag, "_inst"}, {inst_addr, inst_wr_data}, 64'd0);
    check({tag, "_data"}, {data_addr, data_wr_data}, 64'd0);
    check({tag, "_mask"}, data_wr_mask, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_rst(tag);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check({tag, "_rdy"}, rx_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_rst("por");
    rst_n = 1'b1;
    check("por_rdy0", rx_ready, 0);
    @(posedge clk);
    #1 check("por_rdy1", rx_ready, 1);

    // text load
    pw = '{32'h00000013, 32'h00100073};
    frame(8'hA1, 32'h0, 2, 1'b1, 0, 1'b0);
    settle("text");
    check("text_err", err, 0);

    // zero-length frame
    frame(8'hA1, 32'h40, 0, 1'b1, 0, 1'b0);
    settle("zero");
    check("zero_err", err, 0);

    // same text with alternate-cycle stalls
    frame(8'hA1, 32'h0, 2, 1'b1, 1, 1'b0);
    settle("stall");
    check("stall_err", err, 0);

    // exact-fit boundaries
    pw = '{32'hA5A5_5A5A};
    frame(8'hA1, 32'h1FFC, 1, 1'b1, 0, 1'b0);
    frame(8'hA2, 32'h1FFC, 1, 1'b1, 0, 1'b0);
    settle("edge");
    check("edge_err", err, 0);

    // out of range: consumed, no writes
    pw = '{32'h11111111, 32'h22222222};
    frame(8'hA1, 32'h1FFC, 2, 1'b0, 0, 1'b0);
    settle("range");
    check("range_err", err, 1);
    pw = '{32'hCAFEF00D};
    frame(8'hA1, 32'h20, 1, 1'b1, 0, 1'b0);
    settle("after_range");
    check("sticky_err", err, 1);

    // misaligned base
    do_reset("rst1");
    pw = '{32'h33333333};
    frame(8'hA2, 32'h2, 1, 1'b0, 0, 1'b0);
    settle("align");
    check("align_err", err, 1);

    // bad command keeps IDLE
    do_reset("rst2");
    send(8'h55, 0);
    @(negedge clk);
    check("badcmd_err", err, 1);
    check("badcmd_busy", busy, 0);
    pw = '{32'h0BADC0DE};
    frame(8'hA2, 32'h80, 1, 1'b1, 0, 1'b0);
    settle("badcmd_next");

    // reset mid-frame
    do_reset("rst3");
    send(8'hA1, 0);
    send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0);
    @(negedge clk);
    check("mid_busy", busy, 1);
    do_reset("mid");
    repeat (3) @(negedge clk);
    pw = '{32'h76543210};
    frame(8'hA1, 32'h100, 1, 1'b1, 0, 1'b0);
    settle("fresh");
    check("fresh_err", err, 0);

`ifdef LOADER_CHECKSUM_EN
    do_reset("rst4");
    pw = '{32'h04030201};
    frame(8'hA2, 32'h200, 1, 1'b1, 0, 1'b0);
    settle("csum_ok");
    check("csum_ok_err", err, 0);
    frame(8'hA2, 32'h200, 1, 1'b1, 0, 1'b1);
    settle("csum_bad");
    check("csum_bad_err", err, 1);
`endif

    // data load then run
    do_reset("rst5");
    pw = '{32'h12345678};
    frame(8'hA2, 32'h1000, 1, 1'b1, 0, 1'b0);
    settle("dload");
    check("pre_run_core", core_rst_n, 0);
    send(8'hA3, 0);
    check("run_core", core_rst_n, 1);
    check("run_rdy", rx_ready, 0);
    repeat (3) @(negedge clk);
    check("run_core_hold", core_rst_n, 1);
    check("run_rdy_hold", rx_ready, 0);
    check("run_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
